addsub_seq: RTL

ADDSUB_SEQ -- requirements
Module: addsub_seq

---
 rtl/addsub_seq_pkg.sv | 20 ++
 rtl/addsub_nibble.sv | 19 +
 rtl/addsub_seq.sv | 107 ++++++++++
 3 files changed

// File: rtl/addsub_seq_pkg.sv
// rtl/addsub_seq_pkg.sv - shared types, slice width and saturation limit for addsub_seq
package addsub_seq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int NIBBLE_W  = 4;
    localparam int SAT_MAX_W = 64;

    // Most positive (neg=0) or most negative (neg=1) two's-complement value of width w.
    function automatic logic [SAT_MAX_W-1:0] sat_limit(input int w, input logic neg);
        logic [SAT_MAX_W-1:0] msb;
        msb = SAT_MAX_W'(1) << (w - 1);
        return neg ? msb : msb - SAT_MAX_W'(1);
    endfunction

endpackage

// File: rtl/addsub_nibble.sv
// rtl/addsub_nibble.sv - combinational 4-bit adder slice exposing the carry into its MSB
module addsub_nibble (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] s,
    output logic       cout,
    output logic       c3
);

    logic [3:0] lo;

    // Low three bits summed separately so the carry into bit 3 is available for overflow.
    assign lo   = {1'b0, a[2:0]} + {1'b0, b[2:0]} + {3'b000, cin};
    assign c3   = lo[3];
    assign s    = {a[3] ^ b[3] ^ c3, lo[2:0]};
    assign cout = (a[3] & b[3]) | (c3 & (a[3] ^ b[3]));

endmodule

// File: rtl/addsub_seq.sv
// rtl/addsub_seq.sv - nibble-serial signed add/subtract; ADDSUB_SEQ_SATURATE_EN clamps on overflow
module addsub_seq
    import addsub_seq_pkg::*;
#(
    parameter int NIBBLES = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          start,
    input  logic                          sub,
    input  logic [NIBBLE_W*NIBBLES-1:0]   op_a,
    input  logic [NIBBLE_W*NIBBLES-1:0]   op_b,
    output logic                          ready,
    output logic                          busy,
    output logic                          done,
    output logic [NIBBLE_W*NIBBLES-1:0]   result,
    output logic                          ovfl
);

    localparam int W     = NIBBLE_W * NIBBLES;
    localparam int CNT_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(NIBBLES - 1);

`ifdef ADDSUB_SEQ_SATURATE_EN
    localparam logic [W-1:0] SAT_POS = W'(sat_limit(W, 1'b0));
    localparam logic [W-1:0] SAT_NEG = W'(sat_limit(W, 1'b1));
`endif

    state_t              state, state_nxt;
    logic [W-1:0]        a_q, b_q;
    logic                sub_q, carry;
    logic [CNT_W-1:0]    cnt;
    logic [NIBBLE_W-1:0] a_nib, b_nib, s_nib;
    logic                cout, c3, accept, last;

    assign accept = (state == IDLE) && start;
    assign last   = (cnt == LAST);
    assign ready  = (state == IDLE);
    assign busy   = (state == RUN);
    assign done   = (state == DONE);

    // Subtraction is A + ~B + 1: B inverted per slice, the +1 enters as the initial carry.
    always_comb begin
        a_nib = '0;
        b_nib = '0;
        for (int k = 0; k < NIBBLES; k++) begin
            if (cnt == k[CNT_W-1:0]) begin
                a_nib = a_q[k*NIBBLE_W +: NIBBLE_W];
                b_nib = b_q[k*NIBBLE_W +: NIBBLE_W] ^ {NIBBLE_W{sub_q}};
            end
        end
    end

    addsub_nibble u_slice (
        .a    (a_nib),
        .b    (b_nib),
        .cin  (carry),
        .s    (s_nib),
        .cout (cout),
        .c3   (c3)
    );

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = RUN;
            RUN:     if (last)  state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            a_q    <= '0;
            b_q    <= '0;
            sub_q  <= 1'b0;
            carry  <= 1'b0;
            cnt    <= '0;
            result <= '0;
            ovfl   <= 1'b0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                a_q   <= op_a;
                b_q   <= op_b;
                sub_q <= sub;
                carry <= sub;
                cnt   <= '0;
            end else if (state == RUN) begin
                carry <= cout;
                cnt   <= last ? '0 : cnt + CNT_W'(1);
                for (int k = 0; k < NIBBLES; k++) begin
                    if (cnt == k[CNT_W-1:0]) result[k*NIBBLE_W +: NIBBLE_W] <= s_nib;
                end
                if (last) begin
                    ovfl <= c3 ^ cout;
`ifdef ADDSUB_SEQ_SATURATE_EN
                    if (c3 ^ cout) result <= a_q[W-1] ? SAT_NEG : SAT_POS;
`endif
                end
            end
        end
    end

endmodule
